// File: rtl/sm31_pkg.sv
// Shared widths, special encodings and the word classification for the
// sign-magnitude to two's-complement converter.
package sm31_pkg;

    localparam int SM_W = 31;
    localparam int TC_W = 32;
    localparam int MAG_W = SM_W - 1;

    localparam logic [SM_W-1:0] SM_MARKER = 31'h40000000;
    localparam logic [TC_W-1:0] TC_ERR    = 32'h80000000;

    typedef enum logic [1:0] {
        ZERO,
        POS,
        NEG,
        ERR
    } sm_class_e;

endpackage

// File: rtl/sm31_to_twos_if.sv
// Valid/ready stream bundle around sm31_to_twos: sign-magnitude words in,
// two's-complement words plus error flag and error count out.
interface sm31_to_twos_if #(
    parameter int CNT_W = 8
);
    import sm31_pkg::*;

    logic              iValid;
    logic              oReady;
    logic [SM_W-1:0]   iNum;
    logic              iOverflow;
    logic              oValid;
    logic              iReady;
    logic [TC_W-1:0]   oNum;
    logic              oOverflow;
    logic [CNT_W-1:0]  oErrCount;

    // Converter side.
    modport slave (
        input  iValid,
        input  iNum,
        input  iOverflow,
        input  iReady,
        output oReady,
        output oValid,
        output oNum,
        output oOverflow,
        output oErrCount
    );

    // Producer/consumer side.
    modport master (
        output iValid,
        output iNum,
        output iOverflow,
        output iReady,
        input  oReady,
        input  oValid,
        input  oNum,
        input  oOverflow,
        input  oErrCount
    );

endinterface

// File: rtl/sm31_classify.sv
// Combinational classifier: sorts an incoming sign-magnitude word into
// ZERO/POS/NEG/ERR and splits off its magnitude.
module sm31_classify
    import sm31_pkg::*;
(
    input  logic [SM_W-1:0]  iNum,
    input  logic             iOverflow,
    output sm_class_e        cls,
    output logic [MAG_W-1:0] magnitude
);

    always_comb begin
        cls       = POS;
        magnitude = iNum[MAG_W-1:0];
        // Overflow wins over everything; negative zero is the upstream error marker.
        if (iOverflow) begin
            cls = ERR;
        end else if (iNum == '0) begin
            cls = ZERO;
        end else if (iNum == SM_MARKER) begin
            cls = ERR;
        end else if (iNum[SM_W-1]) begin
            cls = NEG;
        end else begin
            cls = POS;
        end
    end

endmodule

// File: rtl/sm31_to_twos.sv
// Two-stage valid/ready pipeline converting 31-bit sign-magnitude words to
// 32-bit two's complement. Define SM31_ERRCNT_EN to build the error counter.
module sm31_to_twos
    import sm31_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sm31_to_twos_if.slave        bus
);

    sm_class_e        cls_w;
    logic [MAG_W-1:0] mag_w;

    logic             s1_valid_q, s1_valid_d;
    sm_class_e        s1_cls_q, s1_cls_d;
    logic [MAG_W-1:0] s1_mag_q, s1_mag_d;
    logic             s1_ovf_q, s1_ovf_d;

    logic             s2_valid_q, s2_valid_d;
    logic [TC_W-1:0]  s2_num_q, s2_num_d;
    logic             s2_ovf_q, s2_ovf_d;

    logic             s2_adv;
    logic             in_ready;
    logic             in_fire;
    logic             s2_err;
    logic [TC_W-1:0]  s2_result;

    sm31_classify u_classify (
        .iNum      (bus.iNum),
        .iOverflow (bus.iOverflow),
        .cls       (cls_w),
        .magnitude (mag_w)
    );

    always_comb begin
        // S2 may load whenever it is empty or its word leaves this cycle.
        s2_adv   = !s2_valid_q || bus.iReady;
        in_ready = !rst && (!s1_valid_q || s2_adv);
        in_fire  = bus.iValid && in_ready;

        s1_valid_d = s1_valid_q;
        s1_cls_d   = s1_cls_q;
        s1_mag_d   = s1_mag_q;
        s1_ovf_d   = s1_ovf_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_cls_d   = cls_w;
            s1_mag_d   = mag_w;
            s1_ovf_d   = bus.iOverflow;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        s2_err = (s1_cls_q == ERR) || s1_ovf_q;
        unique case (s1_cls_q)
            ZERO:    s2_result = '0;
            POS:     s2_result = {{(TC_W-MAG_W){1'b0}}, s1_mag_q};
            NEG:     s2_result = TC_W'(0) - {{(TC_W-MAG_W){1'b0}}, s1_mag_q};
            default: s2_result = TC_ERR;
        endcase

        s2_valid_d = s2_valid_q;
        s2_num_d   = s2_num_q;
        s2_ovf_d   = s2_ovf_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            // Only real words update the data, so the last result stays put across bubbles.
            if (s1_valid_q) begin
                s2_num_d = s2_err ? TC_ERR : s2_result;
                s2_ovf_d = s2_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_cls_q   <= ZERO;
            s1_mag_q   <= '0;
            s1_ovf_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_num_q   <= '0;
            s2_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_cls_q   <= s1_cls_d;
            s1_mag_q   <= s1_mag_d;
            s1_ovf_q   <= s1_ovf_d;
            s2_valid_q <= s2_valid_d;
            s2_num_q   <= s2_num_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    assign bus.oReady    = in_ready;
    assign bus.oValid    = s2_valid_q;
    assign bus.oNum      = s2_num_q;
    assign bus.oOverflow = s2_ovf_q;

`ifdef SM31_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        // Counts delivered error words only, sticking at all-ones.
        if (s2_valid_q && bus.iReady && s2_ovf_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.oErrCount = err_cnt_q;
`else
    assign bus.oErrCount = '0;
`endif

endmodule

// File: tb/tb_sm31_to_twos.sv
// Directed scoreboard bench for sm31_to_twos; expected words come from an
// independent conversion model and are queued at input accept.
module tb_sm31_to_twos;
    import sm31_pkg::*;

    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sm31_to_twos_if #(.CNT_W(CNT_W)) bus ();

    sm31_to_twos #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ovf;
        logic [31:0] num;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cnt_exp = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] held_num;
    logic        held_ovf;
    bit          acc;
    bit          saw_ready_low;

    function automatic exp_t model(input logic [30:0] num, input logic ovf);
        exp_t        e;
        logic [31:0] mag;
        mag = {2'b00, num[29:0]};
        if (ovf || num == 31'h40000000) begin
            e.ovf = 1'b1;
            e.num = 32'h80000000;
        end else if (num[30]) begin
            e.ovf = 1'b0;
            e.num = ~mag + 32'd1;
        end else begin
            e.ovf = 1'b0;
            e.num = mag;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample settled signals, score transfers, advance to next negedge.
    task automatic tick(output bit accepted);
        exp_t e;
        #1;
        accepted = bus.iValid && bus.oReady;
        if (!rst) begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, bus.oValid}, 32'd1);
                check("stall_num", bus.oNum, held_num);
                check("stall_ovf", {31'd0, bus.oOverflow}, {31'd0, held_ovf});
            end
            if (bus.oValid && bus.iReady) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", {31'd0, bus.oValid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_num", bus.oNum, e.num);
                    check("out_ovf", {31'd0, bus.oOverflow}, {31'd0, e.ovf});
                    $display("[TB] out num=%h ovf=%0d", bus.oNum, bus.oOverflow);
`ifdef SM31_ERRCNT_EN
                    if (e.ovf && cnt_exp < 255) cnt_exp++;
`endif
                end
            end
            if (accepted) begin
                sb.push_back(model(bus.iNum, bus.iOverflow));
                $display("[TB] in  num=%h ovf=%0d", bus.iNum, bus.iOverflow);
            end
        end
        prev_stall = !rst && bus.oValid && !bus.iReady;
        held_num   = bus.oNum;
        held_ovf   = bus.oOverflow;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [30:0] num, input logic ovf);
        bit a;
        int n;
        bus.iValid    = 1'b1;
        bus.iNum      = num;
        bus.iOverflow = ovf;
        n = 0;
        a = 1'b0;
        while (!a && n < 50) begin
            tick(a);
            n++;
        end
        if (!a) check("send_timeout", {31'd0, a}, 32'd1);
        bus.iValid    = 1'b0;
        bus.iOverflow = 1'b0;
    endtask

    task automatic drain();
        bit a;
        int n;
        bus.iValid = 1'b0;
        bus.iReady = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick(a);
            n++;
        end
        check("drain_left", sb.size(), 32'd0);
        tick(a);
        check("drain_idle", {31'd0, bus.oValid}, 32'd0);
    endtask

    initial begin
        logic [30:0] burst [4];
        int cyc;
        int idx;
        burst[0] = 31'h00000011;
        burst[1] = 31'h40000022;
        burst[2] = 31'h00000033;
        burst[3] = 31'h40000044;

        bus.iValid    = 1'b0;
        bus.iNum      = '0;
        bus.iOverflow = 1'b0;
        bus.iReady    = 1'b1;

        // Reset state
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_oready", {31'd0, bus.oReady}, 32'd0);
        check("rst_ovalid", {31'd0, bus.oValid}, 32'd0);
        check("rst_onum", bus.oNum, 32'd0);
        check("rst_oovf", {31'd0, bus.oOverflow}, 32'd0);
        check("rst_errcnt", {24'd0, bus.oErrCount}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Latency: 2 cycles from accept to oValid
        bus.iValid = 1'b1;
        bus.iNum   = 31'h00000005;
        tick(acc);
        check("lat_accept", {31'd0, acc}, 32'd1);
        bus.iValid = 1'b0;
        check("lat_c1_valid", {31'd0, bus.oValid}, 32'd0);
        tick(acc);
        check("lat_c2_valid", {31'd0, bus.oValid}, 32'd1);
        check("lat_c2_num", bus.oNum, 32'h00000005);
        drain();

        // Negative conversions, zero and back-to-back throughput
        send(31'h40000003, 1'b0);
        send(31'h7FFFFFFF, 1'b0);
        send(31'h00000000, 1'b0);
        send(31'h3FFFFFFF, 1'b0);
        drain();

        // Error words: marker and flagged overflow
        send(31'h40000000, 1'b0);
        send(31'h00000001, 1'b1);
        drain();
        check("errcnt_two", {24'd0, bus.oErrCount}, cnt_exp);

        // Burst with downstream stall on cycles 2..5
        cyc = 0;
        idx = 0;
        saw_ready_low = 1'b0;
        while ((idx < 4 || sb.size() != 0 || bus.oValid) && cyc < 50) begin
            bus.iReady    = !(cyc >= 2 && cyc <= 5);
            bus.iValid    = (idx < 4);
            bus.iNum      = burst[idx < 4 ? idx : 3];
            bus.iOverflow = 1'b0;
            #1;
            if (bus.iValid && !bus.oReady) saw_ready_low = 1'b1;
            tick(acc);
            if (acc) idx++;
            cyc++;
        end
        check("burst_done", {31'd0, cyc < 50}, 32'd1);
        check("burst_ready_fell", {31'd0, saw_ready_low}, 32'd1);
        drain();

        // Counter saturation
        for (int i = 0; i < 300; i++) send(31'(i), 1'b1);
        drain();
        check("errcnt_sat", {24'd0, bus.oErrCount}, cnt_exp);

        // Reset with both stages full
        bus.iReady = 1'b0;
        send(31'h00000077, 1'b1);
        send(31'h00000078, 1'b0);
        #1;
        check("full_oready", {31'd0, bus.oReady}, 32'd0);
        check("full_ovalid", {31'd0, bus.oValid}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_oready", {31'd0, bus.oReady}, 32'd0);
        tick(acc);
        sb.delete();
        cnt_exp = 0;
        check("rst_mid_ovalid", {31'd0, bus.oValid}, 32'd0);
        check("rst_mid_errcnt", {24'd0, bus.oErrCount}, 32'd0);
        rst = 1'b0;
        bus.iReady = 1'b1;
        send(31'h40000009, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
